oam_dma_arbiter: RTL and testbench

- Sequences the 160-byte OAM DMA copy and shares the single external memory bus (address, data, MREQ, RD, WR) between the SM83 core and the DMA engine.
- Sits between the core's bus pins and the memory/peripheral model.
- Decodes the DMA register write, steals the bus for the whole transfer, and isolates the core while the transfer runs.

---
 rtl/oam_dma_arbiter.sv | 166 ++++++++++++++++
 tb/tb_oam_dma_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_arbiter.sv
// rtl/oam_dma_arbiter.sv - OAM DMA sequencer and core/DMA memory bus arbiter
//
// Purpose: decodes writes to DMA_REG, then takes the shared memory bus and
// copies DMA_LEN bytes from {src, 00} to DEST_BASE with alternating one-cycle
// READ/WRITE bus cycles. The core is isolated from memory while this runs.
//
// Ports:
//   CLK, RESET              clock, asynchronous active-high reset
//   CPU_A/DO/MREQ/RD/WR     core bus request side
//   CPU_DI                  read data returned to the core
//   MEM_A/DO/MREQ/RD/WR     memory bus, driven by the core or the DMA engine
//   MEM_DI                  memory read data
//   DMA_ACTIVE              engine owns the bus (START/READ/WRITE)
//   DMA_DONE                one-cycle pulse after the last byte is written
module oam_dma_arbiter #(
  parameter int          DMA_LEN        = 160,
  parameter logic [15:0] DEST_BASE      = 16'hFE00,
  parameter logic [15:0] DMA_REG        = 16'hFF46,
  parameter int          STARTUP_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] CPU_A,
  input  logic [7:0]  CPU_DO,
  output logic [7:0]  CPU_DI,
  input  logic        CPU_MREQ,
  input  logic        CPU_RD,
  input  logic        CPU_WR,
  output logic [15:0] MEM_A,
  output logic [7:0]  MEM_DO,
  input  logic [7:0]  MEM_DI,
  output logic        MEM_MREQ,
  output logic        MEM_RD,
  output logic        MEM_WR,
  output logic        DMA_ACTIVE,
  output logic        DMA_DONE
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_READ,
    S_WRITE
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);
  localparam logic [1:0] STARTUP  = 2'(STARTUP_CYCLES);

  state_t     state_q, state_d;
  logic [7:0] src_q, src_d;
  logic [7:0] idx_q, idx_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;

  logic       reg_hit;
  logic       start;
  logic [7:0] src_eff;

  assign reg_hit = (CPU_A == DMA_REG);
  assign start   = CPU_MREQ & CPU_WR & reg_hit;
  // Sources in the echo region E0..FF fold back onto C0..DF.
  assign src_eff = (src_q >= 8'hE0) ? (src_q - 8'h20) : src_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      src_q   <= 8'hFF;
      idx_q   <= 8'h00;
      cnt_q   <= 2'd0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    done_d  = 1'b0;

    case (state_q)
      S_START: begin
        // START is held for at least one cycle; the counter reaching zero
        // on this cycle ends it, so STARTUP_CYCLES=1 gives a single cycle.
        cnt_d = (cnt_q == 2'd0) ? 2'd0 : (cnt_q - 2'd1);
        if (cnt_q <= 2'd1) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        data_d  = MEM_DI;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_READ;
        end
      end
      default: begin
      end
    endcase

    // A register write restarts from any state, abandoning the byte in
    // flight and suppressing a DONE that would otherwise fire this cycle.
    if (start) begin
      src_d   = CPU_DO;
      idx_d   = 8'h00;
      cnt_d   = STARTUP;
      state_d = S_START;
      done_d  = 1'b0;
    end
  end

  // Bus outputs depend only on state, registers and core inputs, never on
  // MEM_DI, so memory read data cannot loop back into the address/strobes.
  always_comb begin
    MEM_A    = 16'h0000;
    MEM_DO   = 8'h00;
    MEM_MREQ = 1'b0;
    MEM_RD   = 1'b0;
    MEM_WR   = 1'b0;

    case (state_q)
      S_IDLE: begin
        MEM_A    = CPU_A;
        MEM_DO   = CPU_DO;
        // The DMA register lives here, so its accesses never reach memory.
        MEM_MREQ = CPU_MREQ & ~reg_hit;
        MEM_RD   = CPU_RD & ~reg_hit;
        MEM_WR   = CPU_WR & ~reg_hit;
      end
      S_READ: begin
        MEM_A    = {src_eff, idx_q};
        MEM_MREQ = 1'b1;
        MEM_RD   = 1'b1;
      end
      S_WRITE: begin
        MEM_A    = DEST_BASE + {8'h00, idx_q};
        MEM_DO   = data_q;
        MEM_MREQ = 1'b1;
        MEM_WR   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign DMA_ACTIVE = (state_q != S_IDLE);
  assign DMA_DONE   = done_q;
  assign CPU_DI     = reg_hit ? src_q : (DMA_ACTIVE ? 8'hFF : MEM_DI);

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb/tb_oam_dma_arbiter.sv - self-checking bench for oam_dma_arbiter
module tb_oam_dma_arbiter;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] CPU_A = 16'h0000;
  logic [7:0]  CPU_DO = 8'h00;
  logic [7:0]  CPU_DI;
  logic        CPU_MREQ = 1'b0;
  logic        CPU_RD = 1'b0;
  logic        CPU_WR = 1'b0;
  logic [15:0] MEM_A;
  logic [7:0]  MEM_DO;
  logic [7:0]  MEM_DI;
  logic        MEM_MREQ;
  logic        MEM_RD;
  logic        MEM_WR;
  logic        DMA_ACTIVE;
  logic        DMA_DONE;

  logic [7:0]  mem [0:65535];

  typedef struct packed {
    logic [15:0] a;
    logic        wr;
    logic [7:0]  d;
  } op_t;

  op_t exp_q[$];
  op_t op;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_at = 0;
  int start_cyc = 0;
  logic act_at_done = 1'b1;
  logic mon_en = 1'b0;

  oam_dma_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .CPU_A(CPU_A), .CPU_DO(CPU_DO), .CPU_DI(CPU_DI),
    .CPU_MREQ(CPU_MREQ), .CPU_RD(CPU_RD), .CPU_WR(CPU_WR),
    .MEM_A(MEM_A), .MEM_DO(MEM_DO), .MEM_DI(MEM_DI),
    .MEM_MREQ(MEM_MREQ), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
    .DMA_ACTIVE(DMA_ACTIVE), .DMA_DONE(DMA_DONE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  assign MEM_DI = mem[MEM_A];
  always @(posedge CLK) if (MEM_MREQ && MEM_WR) mem[MEM_A] <= MEM_DO;

  // Scoreboard: every DMA bus cycle must match the next expected operation.
  always @(negedge CLK) begin
    if (mon_en && MEM_MREQ && (MEM_RD || MEM_WR)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL bus_op: got A=%h rd=%b wr=%b do=%h, required no bus cycle",
                 MEM_A, MEM_RD, MEM_WR, MEM_DO);
      end else begin
        op = exp_q.pop_front();
        if (MEM_A !== op.a || MEM_WR !== op.wr || MEM_RD !== ~op.wr ||
            (op.wr && MEM_DO !== op.d)) begin
          miscompares++;
          $display("FAIL bus_op: got A=%h rd=%b wr=%b do=%h, required A=%h wr=%b do=%h",
                   MEM_A, MEM_RD, MEM_WR, MEM_DO, op.a, op.wr, op.d);
        end
      end
    end
    if (mon_en && DMA_DONE === 1'b1) begin
      done_cnt++;
      done_at = cyc;
      act_at_done = DMA_ACTIVE;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cpu_idle();
    CPU_A = 16'h0000; CPU_DO = 8'h00; CPU_MREQ = 1'b0; CPU_RD = 1'b0; CPU_WR = 1'b0;
  endtask

  // Returns at the negedge of the first START cycle.
  task automatic cpu_write_reg(input logic [7:0] v);
    @(negedge CLK);
    CPU_A = 16'hFF46; CPU_DO = v; CPU_MREQ = 1'b1; CPU_WR = 1'b1; CPU_RD = 1'b0;
    @(negedge CLK);
    cpu_idle();
  endtask

  task automatic push_transfer(input logic [7:0] s);
    logic [7:0]  se;
    logic [15:0] ra;
    se = (s >= 8'hE0) ? s - 8'h20 : s;
    for (int i = 0; i < 160; i++) begin
      ra = {se, 8'(i)};
      exp_q.push_back('{a: ra, wr: 1'b0, d: 8'h00});
      exp_q.push_back('{a: 16'hFE00 + 16'(i), wr: 1'b1, d: mem[ra]});
    end
  endtask

  task automatic wait_done(input int d0);
    for (int c = 0; c < 800 && done_cnt == d0; c++) @(negedge CLK);
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset();
    cpu_idle();
    repeat (3) @(negedge CLK);
    vectors++;
    if (DMA_ACTIVE !== 1'b0 || DMA_DONE !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got active=%b done=%b, required 0 0", DMA_ACTIVE, DMA_DONE);
    end
    #2 RESET = 1'b0;
    @(negedge CLK);
    CPU_A = 16'hFF46; CPU_MREQ = 1'b1; CPU_RD = 1'b1;
    #1;
    vectors++;
    if (CPU_DI !== 8'hFF || MEM_MREQ !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_src: got di=%h mreq=%b, required FF 0", CPU_DI, MEM_MREQ);
    end
    @(negedge CLK);
    cpu_idle();
  endtask

  task automatic test_passthrough();
    mem[16'h8000] = 8'h3C;
    @(negedge CLK);
    CPU_A = 16'h8000; CPU_MREQ = 1'b1; CPU_RD = 1'b1;
    #1;
    vectors++;
    if (MEM_A !== 16'h8000 || MEM_MREQ !== 1'b1 || MEM_RD !== 1'b1 || MEM_WR !== 1'b0 ||
        CPU_DI !== 8'h3C) begin
      miscompares++;
      $display("FAIL pass_read: got A=%h mreq=%b rd=%b wr=%b di=%h, required 8000 1 1 0 3C",
               MEM_A, MEM_MREQ, MEM_RD, MEM_WR, CPU_DI);
    end
    @(negedge CLK);
    CPU_RD = 1'b0; CPU_WR = 1'b1; CPU_DO = 8'hA5;
    #1;
    vectors++;
    if (MEM_A !== 16'h8000 || MEM_WR !== 1'b1 || MEM_RD !== 1'b0 || MEM_DO !== 8'hA5) begin
      miscompares++;
      $display("FAIL pass_write: got A=%h wr=%b rd=%b do=%h, required 8000 1 0 A5",
               MEM_A, MEM_WR, MEM_RD, MEM_DO);
    end
    @(negedge CLK);
    cpu_idle();
    vectors++;
    if (mem[16'h8000] !== 8'hA5 || DMA_ACTIVE !== 1'b0) begin
      miscompares++;
      $display("FAIL pass_mem: got mem=%h active=%b, required A5 0", mem[16'h8000], DMA_ACTIVE);
    end
  endtask

  task automatic check_end(input int d0, input string name);
    vectors++;
    if (done_cnt !== d0 + 1 || done_at - start_cyc !== 321 || act_at_done !== 1'b0 ||
        exp_q.size() !== 0 || DMA_DONE !== 1'b0 || DMA_ACTIVE !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_end: got dones=%0d at=%0d act=%b left=%0d, required dones=%0d at=321 act=0 left=0",
               name, done_cnt - d0, done_at - start_cyc, act_at_done, exp_q.size(), 1);
    end
  endtask

  task automatic test_basic_copy();
    int d0;
    for (int i = 0; i < 160; i++) begin
      mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
      mem[16'hFE00 + 16'(i)] = 8'h00;
    end
    mon_en = 1'b1;
    d0 = done_cnt;
    cpu_write_reg(8'hC0);
    start_cyc = cyc;
    vectors++;
    if (DMA_ACTIVE !== 1'b1 || MEM_MREQ !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_start: got active=%b mreq=%b, required 1 0", DMA_ACTIVE, MEM_MREQ);
    end
    push_transfer(8'hC0);
    wait_done(d0);
    check_end(d0, "basic");
    for (int i = 0; i < 160; i++) begin
      vectors++;
      if (mem[16'hFE00 + 16'(i)] !== (8'(i) ^ 8'h5A)) begin
        miscompares++;
        $display("FAIL basic_oam[%0d]: got %h, required %h", i, mem[16'hFE00 + 16'(i)], 8'(i) ^ 8'h5A);
      end
    end
    mon_en = 1'b0;
  endtask

  task automatic test_isolation();
    int d0;
    mem[16'h1234] = 8'h77;
    mem[16'hC100] = 8'hAA;
    mon_en = 1'b1;
    d0 = done_cnt;
    cpu_write_reg(8'hC0);
    start_cyc = cyc;
    push_transfer(8'hC0);
    repeat (10) @(negedge CLK);
    CPU_A = 16'h1234; CPU_MREQ = 1'b1; CPU_RD = 1'b1;
    #1;
    vectors++;
    if (CPU_DI !== 8'hFF || MEM_A === 16'h1234) begin
      miscompares++;
      $display("FAIL iso_read: got di=%h memA=%h, required di=FF memA!=1234", CPU_DI, MEM_A);
    end
    @(negedge CLK);
    CPU_A = 16'hC100; CPU_DO = 8'h55; CPU_RD = 1'b0; CPU_WR = 1'b1;
    #1;
    vectors++;
    if (MEM_A === 16'hC100) begin
      miscompares++;
      $display("FAIL iso_write: got memA=%h, required memA!=C100", MEM_A);
    end
    @(negedge CLK);
    CPU_A = 16'hFF46; CPU_WR = 1'b0; CPU_RD = 1'b1;
    #1;
    vectors++;
    if (CPU_DI !== 8'hC0) begin
      miscompares++;
      $display("FAIL iso_regread: got %h, required C0", CPU_DI);
    end
    @(negedge CLK);
    cpu_idle();
    wait_done(d0);
    check_end(d0, "iso");
    vectors++;
    if (mem[16'hC100] !== 8'hAA || mem[16'h1234] !== 8'h77) begin
      miscompares++;
      $display("FAIL iso_mem: got C100=%h 1234=%h, required AA 77", mem[16'hC100], mem[16'h1234]);
    end
    mon_en = 1'b0;
  endtask

  task automatic test_restart();
    int  d0;
    logic hit;
    for (int i = 0; i < 160; i++) mem[16'hD000 + 16'(i)] = 8'(i) ^ 8'hC3;
    mon_en = 1'b1;
    d0 = done_cnt;
    cpu_write_reg(8'hC0);
    start_cyc = cyc;
    push_transfer(8'hC0);
    hit = 1'b0;
    for (int c = 0; c < 400 && !hit; c++) begin
      @(negedge CLK);
      if (MEM_RD === 1'b1 && MEM_A === 16'hC040) hit = 1'b1;
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL restart_find: got no read of C040, required one within 400 cycles");
    end
    CPU_A = 16'hFF46; CPU_DO = 8'hD0; CPU_MREQ = 1'b1; CPU_WR = 1'b1;
    @(negedge CLK);
    cpu_idle();
    vectors++;
    if (DMA_ACTIVE !== 1'b1 || MEM_MREQ !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_start: got active=%b mreq=%b, required 1 0", DMA_ACTIVE, MEM_MREQ);
    end
    exp_q.delete();
    start_cyc = cyc;
    push_transfer(8'hD0);
    wait_done(d0);
    check_end(d0, "restart");
    vectors++;
    if (mem[16'hFE40] !== (8'h40 ^ 8'hC3)) begin
      miscompares++;
      $display("FAIL restart_oam: got %h, required %h", mem[16'hFE40], 8'h40 ^ 8'hC3);
    end
    mon_en = 1'b0;
  endtask

  task automatic test_echo();
    int d0;
    for (int i = 0; i < 160; i++) mem[16'hC100 + 16'(i)] = 8'(i) ^ 8'hA5;
    mon_en = 1'b1;
    d0 = done_cnt;
    cpu_write_reg(8'hE1);
    start_cyc = cyc;
    push_transfer(8'hE1);
    repeat (20) @(negedge CLK);
    CPU_A = 16'hFF46; CPU_MREQ = 1'b1; CPU_RD = 1'b1;
    #1;
    vectors++;
    if (CPU_DI !== 8'hE1) begin
      miscompares++;
      $display("FAIL echo_regread: got %h, required E1", CPU_DI);
    end
    @(negedge CLK);
    cpu_idle();
    wait_done(d0);
    check_end(d0, "echo");
    vectors++;
    if (mem[16'hFE05] !== (8'h05 ^ 8'hA5)) begin
      miscompares++;
      $display("FAIL echo_oam: got %h, required %h", mem[16'hFE05], 8'h05 ^ 8'hA5);
    end
    mon_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] snap [0:127];
    logic hit;
    for (int i = 0; i < 128; i++) snap[i] = mem[16'hFE20 + 16'(i)];
    mon_en = 1'b1;
    cpu_write_reg(8'hC0);
    push_transfer(8'hC0);
    hit = 1'b0;
    for (int c = 0; c < 400 && !hit; c++) begin
      @(negedge CLK);
      if (MEM_RD === 1'b1 && MEM_A === 16'hC020) hit = 1'b1;
    end
    mon_en = 1'b0;
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL rstmid_find: got no read of C020, required one within 400 cycles");
    end
    #2 RESET = 1'b1;
    #1;
    vectors++;
    if (DMA_ACTIVE !== 1'b0 || MEM_RD !== 1'b0 || MEM_WR !== 1'b0 || MEM_MREQ !== 1'b0 ||
        DMA_DONE !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_drop: got active=%b rd=%b wr=%b mreq=%b done=%b, required all 0",
               DMA_ACTIVE, MEM_RD, MEM_WR, MEM_MREQ, DMA_DONE);
    end
    exp_q.delete();
    repeat (2) @(negedge CLK);
    #2 RESET = 1'b0;
    @(negedge CLK);
    CPU_A = 16'hFF46; CPU_MREQ = 1'b1; CPU_RD = 1'b1;
    #1;
    vectors++;
    if (CPU_DI !== 8'hFF || MEM_MREQ !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_src: got di=%h mreq=%b, required FF 0", CPU_DI, MEM_MREQ);
    end
    @(negedge CLK);
    CPU_A = 16'h8000;
    #1;
    vectors++;
    if (MEM_A !== 16'h8000 || MEM_RD !== 1'b1 || CPU_DI !== 8'hA5 || DMA_ACTIVE !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_pass: got A=%h rd=%b di=%h active=%b, required 8000 1 A5 0",
               MEM_A, MEM_RD, CPU_DI, DMA_ACTIVE);
    end
    @(negedge CLK);
    cpu_idle();
    repeat (4) @(negedge CLK);
    for (int i = 0; i < 128; i++) begin
      vectors++;
      if (mem[16'hFE20 + 16'(i)] !== snap[i]) begin
        miscompares++;
        $display("FAIL rstmid_oam[%0d]: got %h, required %h", i + 32, mem[16'hFE20 + 16'(i)], snap[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h33;
    test_reset();
    test_passthrough();
    test_basic_copy();
    test_isolation();
    test_restart();
    test_echo();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
